// File: rtl/voice_alloc.sv
// Voice allocator: maps MIDI note-on/off events onto synth voice slots,
// tracking per-slot state and age and stealing the oldest voice when full.
//
// state    | meaning
// ST_IDLE  | ready for an event; strobes from the last ISSUE are visible here
// ST_SCAN  | one slot examined per cycle, collecting match/free/oldest candidates
// ST_ISSUE | pick the slot, update the slot table, load the output registers
module voice_alloc #(
    parameter int NUM_VOICES = 16,
    parameter int AGE_W      = 8
) (
    input  logic       clk32,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_on,
    input  logic [6:0] in_note,
    input  logic [6:0] in_velocity,
    input  logic [3:0] in_channel,
    output logic       note_pressed,
    output logic       note_released,
    output logic [6:0] note,
    output logic [6:0] velocity,
    output logic [3:0] channel,
    output logic [7:0] addr,
    output logic       stolen,
    output logic       miss
);
    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_ISSUE = 2'd2;

    localparam logic [1:0] SL_FREE = 2'd0;
    localparam logic [1:0] SL_HELD = 2'd1;
    localparam logic [1:0] SL_REL  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] scan_idx_q, scan_idx_d;

    logic             ev_on_q, ev_on_d;
    logic [6:0]       ev_note_q, ev_note_d;
    logic [6:0]       ev_vel_q, ev_vel_d;
    logic [3:0]       ev_ch_q, ev_ch_d;

    logic             match_vld_q, match_vld_d;
    logic [IDX_W-1:0] match_idx_q, match_idx_d;
    logic             free_vld_q, free_vld_d;
    logic [IDX_W-1:0] free_idx_q, free_idx_d;
    logic             rel_vld_q, rel_vld_d;
    logic [IDX_W-1:0] rel_idx_q, rel_idx_d;
    logic [AGE_W-1:0] rel_age_q, rel_age_d;
    logic             held_vld_q, held_vld_d;
    logic [IDX_W-1:0] held_idx_q, held_idx_d;
    logic [AGE_W-1:0] held_age_q, held_age_d;

    logic [1:0]       slot_st_q   [NUM_VOICES];
    logic [1:0]       slot_st_d   [NUM_VOICES];
    logic [6:0]       slot_note_q [NUM_VOICES];
    logic [6:0]       slot_note_d [NUM_VOICES];
    logic [3:0]       slot_ch_q   [NUM_VOICES];
    logic [3:0]       slot_ch_d   [NUM_VOICES];
    logic [AGE_W-1:0] slot_age_q  [NUM_VOICES];
    logic [AGE_W-1:0] slot_age_d  [NUM_VOICES];

    logic             note_pressed_q, note_pressed_d;
    logic             note_released_q, note_released_d;
    logic             stolen_q, stolen_d;
    logic             miss_q, miss_d;
    logic [6:0]       note_q, note_d;
    logic [6:0]       velocity_q, velocity_d;
    logic [3:0]       channel_q, channel_d;
    logic [7:0]       addr_q, addr_d;

    logic [1:0]       cur_st;
    logic [AGE_W-1:0] cur_age;
    logic             cur_hit;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_steal;

    always_comb begin
        state_d     = state_q;
        scan_idx_d  = scan_idx_q;
        ev_on_d     = ev_on_q;
        ev_note_d   = ev_note_q;
        ev_vel_d    = ev_vel_q;
        ev_ch_d     = ev_ch_q;
        match_vld_d = match_vld_q;
        match_idx_d = match_idx_q;
        free_vld_d  = free_vld_q;
        free_idx_d  = free_idx_q;
        rel_vld_d   = rel_vld_q;
        rel_idx_d   = rel_idx_q;
        rel_age_d   = rel_age_q;
        held_vld_d  = held_vld_q;
        held_idx_d  = held_idx_q;
        held_age_d  = held_age_q;
        slot_st_d   = slot_st_q;
        slot_note_d = slot_note_q;
        slot_ch_d   = slot_ch_q;
        slot_age_d  = slot_age_q;

        note_pressed_d  = 1'b0;
        note_released_d = 1'b0;
        stolen_d        = 1'b0;
        miss_d          = 1'b0;
        note_d          = note_q;
        velocity_d      = velocity_q;
        channel_d       = channel_q;
        addr_d          = addr_q;

        cur_st    = slot_st_q[scan_idx_q];
        cur_age   = slot_age_q[scan_idx_q];
        cur_hit   = (cur_st != SL_FREE) && (slot_note_q[scan_idx_q] == ev_note_q)
                    && (slot_ch_q[scan_idx_q] == ev_ch_q);
        sel_idx   = '0;
        sel_steal = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    // A note-on with zero velocity is treated as a note-off.
                    ev_on_d     = in_on && (in_velocity != 7'd0);
                    ev_note_d   = in_note;
                    ev_vel_d    = in_velocity;
                    ev_ch_d     = in_channel;
                    scan_idx_d  = '0;
                    match_vld_d = 1'b0;
                    free_vld_d  = 1'b0;
                    rel_vld_d   = 1'b0;
                    held_vld_d  = 1'b0;
                    state_d     = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (!match_vld_q && cur_hit) begin
                    match_vld_d = 1'b1;
                    match_idx_d = scan_idx_q;
                end
                if (!free_vld_q && cur_st == SL_FREE) begin
                    free_vld_d = 1'b1;
                    free_idx_d = scan_idx_q;
                end
                // Strict compare keeps the lowest index on equal ages.
                if (cur_st == SL_REL && (!rel_vld_q || cur_age > rel_age_q)) begin
                    rel_vld_d = 1'b1;
                    rel_idx_d = scan_idx_q;
                    rel_age_d = cur_age;
                end
                if (cur_st == SL_HELD && (!held_vld_q || cur_age > held_age_q)) begin
                    held_vld_d = 1'b1;
                    held_idx_d = scan_idx_q;
                    held_age_d = cur_age;
                end
                if (scan_idx_q == LAST_IDX) begin
                    state_d = ST_ISSUE;
                end else begin
                    scan_idx_d = scan_idx_q + 1'b1;
                end
            end
            ST_ISSUE: begin
                state_d = ST_IDLE;
                if (ev_on_q) begin
                    if (match_vld_q) begin
                        sel_idx = match_idx_q;
                    end else if (free_vld_q) begin
                        sel_idx = free_idx_q;
                    end else if (rel_vld_q) begin
                        sel_idx = rel_idx_q;
                    end else begin
                        sel_idx   = held_idx_q;
                        sel_steal = 1'b1;
                    end
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        if (IDX_W'(i) == sel_idx) begin
                            slot_st_d[i]   = SL_HELD;
                            slot_note_d[i] = ev_note_q;
                            slot_ch_d[i]   = ev_ch_q;
                            slot_age_d[i]  = '0;
                        end else if (slot_st_q[i] != SL_FREE && slot_age_q[i] != '1) begin
                            slot_age_d[i] = slot_age_q[i] + 1'b1;
                        end
                    end
                    note_pressed_d = 1'b1;
                    stolen_d       = sel_steal;
                    addr_d         = 8'(sel_idx);
                    note_d         = ev_note_q;
                    velocity_d     = ev_vel_q;
                    channel_d      = ev_ch_q;
                end else if (match_vld_q) begin
                    if (slot_st_q[match_idx_q] == SL_HELD) begin
                        slot_st_d[match_idx_q] = SL_REL;
                    end
                    note_released_d = 1'b1;
                    addr_d          = 8'(match_idx_q);
                    note_d          = ev_note_q;
                    velocity_d      = ev_vel_q;
                    channel_d       = ev_ch_q;
                end else begin
                    miss_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk32 or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            scan_idx_q      <= '0;
            ev_on_q         <= 1'b0;
            ev_note_q       <= '0;
            ev_vel_q        <= '0;
            ev_ch_q         <= '0;
            match_vld_q     <= 1'b0;
            match_idx_q     <= '0;
            free_vld_q      <= 1'b0;
            free_idx_q      <= '0;
            rel_vld_q       <= 1'b0;
            rel_idx_q       <= '0;
            rel_age_q       <= '0;
            held_vld_q      <= 1'b0;
            held_idx_q      <= '0;
            held_age_q      <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                slot_st_q[i]   <= SL_FREE;
                slot_note_q[i] <= '0;
                slot_ch_q[i]   <= '0;
                slot_age_q[i]  <= '0;
            end
            note_pressed_q  <= 1'b0;
            note_released_q <= 1'b0;
            stolen_q        <= 1'b0;
            miss_q          <= 1'b0;
            note_q          <= '0;
            velocity_q      <= '0;
            channel_q       <= '0;
            addr_q          <= '0;
        end else begin
            state_q         <= state_d;
            scan_idx_q      <= scan_idx_d;
            ev_on_q         <= ev_on_d;
            ev_note_q       <= ev_note_d;
            ev_vel_q        <= ev_vel_d;
            ev_ch_q         <= ev_ch_d;
            match_vld_q     <= match_vld_d;
            match_idx_q     <= match_idx_d;
            free_vld_q      <= free_vld_d;
            free_idx_q      <= free_idx_d;
            rel_vld_q       <= rel_vld_d;
            rel_idx_q       <= rel_idx_d;
            rel_age_q       <= rel_age_d;
            held_vld_q      <= held_vld_d;
            held_idx_q      <= held_idx_d;
            held_age_q      <= held_age_d;
            slot_st_q       <= slot_st_d;
            slot_note_q     <= slot_note_d;
            slot_ch_q       <= slot_ch_d;
            slot_age_q      <= slot_age_d;
            note_pressed_q  <= note_pressed_d;
            note_released_q <= note_released_d;
            stolen_q        <= stolen_d;
            miss_q          <= miss_d;
            note_q          <= note_d;
            velocity_q      <= velocity_d;
            channel_q       <= channel_d;
            addr_q          <= addr_d;
        end
    end

    assign in_ready      = (state_q == ST_IDLE);
    assign note_pressed  = note_pressed_q;
    assign note_released = note_released_q;
    assign stolen        = stolen_q;
    assign miss          = miss_q;
    assign note          = note_q;
    assign velocity      = velocity_q;
    assign channel       = channel_q;
    assign addr          = addr_q;

endmodule
